mem_stage_lsu: RTL and testbench

- MEM stage of the RISC-V core. Sits between EX/MEM and MEM_WB.
- Passes ALU results straight through to MEM_WB.
- Executes LB/LH/LW/LBU/LHU/SB/SH/SW as byte-serial transfers on an 8-bit memory-controller port.
- Holds the pipeline with stall_req until the access completes.

---
 rtl/mem_stage_lsu_pkg.sv | 43 ++++
 rtl/mem_stage_lsu_if.sv | 16 +
 rtl/mem_stage_lsu_extend.sv | 23 ++
 rtl/mem_stage_lsu.sv | 140 ++++++++++++++
 tb/tb_mem_stage_lsu.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit.
// Contains the memory-op codes, the FSM states and the op-decoding helpers.
package mem_stage_lsu_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [3:0] {
      MEMOP_NONE = 4'd0,
      MEMOP_LB   = 4'd1,
      MEMOP_LH   = 4'd2,
      MEMOP_LW   = 4'd3,
      MEMOP_LBU  = 4'd4,
      MEMOP_LHU  = 4'd5,
      MEMOP_SB   = 4'd6,
      MEMOP_SH   = 4'd7,
      MEMOP_SW   = 4'd8
   } memop_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Codes 9-15 are not memory ops and fall through like NONE.
   function automatic logic is_mem_op(input logic [3:0] op);
      return (op >= 4'd1) && (op <= 4'd8);
   endfunction

   function automatic logic is_store_op(input logic [3:0] op);
      return (op >= 4'd6) && (op <= 4'd8);
   endfunction

   // Index of the final byte of the transfer (length minus one).
   function automatic logic [1:0] last_byte(input logic [3:0] op);
      case (op)
         MEMOP_LH, MEMOP_LHU, MEMOP_SH: return 2'd1;
         MEMOP_LW, MEMOP_SW:            return 2'd3;
         default:                       return 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Byte-wide memory-controller port driven by the load/store unit.
interface mem_stage_lsu_if #(
   parameter int XLEN = 32
);
   import mem_stage_lsu_pkg::*;

   logic              req;
   logic              we;
   logic [XLEN-1:0]   addr;
   logic [BYTE_W-1:0] wdata;
   logic [BYTE_W-1:0] rdata;
   logic              ack;

   modport master (output req, we, addr, wdata, input rdata, ack);
   modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/mem_stage_lsu_extend.sv
// Widens the assembled load buffer to XLEN with sign or zero extension by op.
module mem_stage_lsu_extend
   import mem_stage_lsu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  memop_e          op,
   input  logic [XLEN-1:0] raw,
   output logic [XLEN-1:0] ext
);

   always_comb begin
      case (op)
         MEMOP_LB:  ext = {{(XLEN-8){raw[7]}}, raw[7:0]};
         MEMOP_LH:  ext = {{(XLEN-16){raw[15]}}, raw[15:0]};
         MEMOP_LBU: ext = {{(XLEN-8){1'b0}}, raw[7:0]};
         MEMOP_LHU: ext = {{(XLEN-16){1'b0}}, raw[15:0]};
         MEMOP_LW:  ext = raw;
         default:   ext = '0;
      endcase
   end

endmodule

// File: rtl/mem_stage_lsu.sv
// RISC-V MEM stage: ALU results pass straight through, loads/stores run as
// byte-serial transfers on an 8-bit port while stall_req holds the pipeline.
module mem_stage_lsu
   import mem_stage_lsu_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int RAW  = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            rdy,
   input  logic            ex_we,
   input  logic [RAW-1:0]  ex_waddr,
   input  logic [XLEN-1:0] ex_wdata,
   input  logic [3:0]      ex_memop,
   input  logic [XLEN-1:0] ex_maddr,
   input  logic [XLEN-1:0] ex_sdata,
   mem_stage_lsu_if.master bus,
   output logic            stall_req,
   output logic            mem_we,
   output logic [RAW-1:0]  mem_waddr,
   output logic [XLEN-1:0] mem_wdata
);

   localparam int NB    = XLEN / BYTE_W;
   localparam int SEL_W = $clog2(XLEN);

   state_e          state_reg, state_next;
   memop_e          op_reg, op_next;
   logic [1:0]      cnt_reg, cnt_next;
   logic [1:0]      last_reg, last_next;
   logic [XLEN-1:0] addr_reg, addr_next;
   logic [XLEN-1:0] sdata_reg, sdata_next;
   logic [XLEN-1:0] buf_reg, buf_next;
   logic [RAW-1:0]  waddr_reg, waddr_next;
   logic [XLEN-1:0] ext_data;
   logic [SEL_W-1:0] byte_sel;
   logic            capture;

   assign byte_sel = SEL_W'({cnt_reg, 3'b000});
   assign capture  = (state_reg == ST_BUSY) && bus.ack && !is_store_op(op_reg);

   // Each lane of the load buffer only takes the read byte when cnt points at it.
   for (genvar gi = 0; gi < NB; gi++) begin : g_lane
      assign buf_next[gi*BYTE_W +: BYTE_W] =
         (capture && (cnt_reg == 2'(gi))) ? bus.rdata : buf_reg[gi*BYTE_W +: BYTE_W];
   end

   mem_stage_lsu_extend #(.XLEN(XLEN)) u_extend (
      .op  (op_reg),
      .raw (buf_reg),
      .ext (ext_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_IDLE;
         op_reg    <= MEMOP_NONE;
         cnt_reg   <= '0;
         last_reg  <= '0;
         addr_reg  <= '0;
         sdata_reg <= '0;
         buf_reg   <= '0;
         waddr_reg <= '0;
      end else if (rdy) begin
         state_reg <= state_next;
         op_reg    <= op_next;
         cnt_reg   <= cnt_next;
         last_reg  <= last_next;
         addr_reg  <= addr_next;
         sdata_reg <= sdata_next;
         buf_reg   <= buf_next;
         waddr_reg <= waddr_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      op_next    = op_reg;
      cnt_next   = cnt_reg;
      last_next  = last_reg;
      addr_next  = addr_reg;
      sdata_next = sdata_reg;
      waddr_next = waddr_reg;
      stall_req  = 1'b0;
      mem_we     = 1'b0;
      mem_waddr  = '0;
      mem_wdata  = '0;
      bus.req    = 1'b0;
      bus.we     = 1'b0;
      bus.addr   = '0;
      bus.wdata  = '0;

      case (state_reg)
         ST_IDLE: begin
            // Reset while idle forces every output low.
            if (!rst) begin
               if (is_mem_op(ex_memop)) begin
                  stall_req  = 1'b1;
                  state_next = ST_BUSY;
                  op_next    = memop_e'(ex_memop);
                  addr_next  = ex_maddr;
                  sdata_next = ex_sdata;
                  waddr_next = ex_waddr;
                  last_next  = last_byte(ex_memop);
                  cnt_next   = '0;
               end else begin
                  mem_we    = ex_we;
                  mem_waddr = ex_waddr;
                  mem_wdata = ex_wdata;
               end
            end
         end
         ST_BUSY: begin
            stall_req = 1'b1;
            bus.req   = 1'b1;
            bus.we    = is_store_op(op_reg);
            bus.addr  = addr_reg + XLEN'(cnt_reg);
            bus.wdata = sdata_reg[byte_sel +: BYTE_W];
            if (bus.ack) begin
               cnt_next = cnt_reg + 2'd1;
               if (cnt_reg == last_reg) begin
                  state_next = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            if (!is_store_op(op_reg)) begin
               mem_we    = 1'b1;
               mem_waddr = waddr_reg;
               mem_wdata = ext_data;
            end
            state_next = ST_IDLE;
            cnt_next   = '0;
         end
         default: state_next = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: table of load/store transfers against a
// byte-level memory responder, plus pass-through and reset-abort sequences.
module tb_mem_stage_lsu;
   import mem_stage_lsu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        rdy;
   logic        ex_we;
   logic [4:0]  ex_waddr;
   logic [31:0] ex_wdata;
   logic [3:0]  ex_memop;
   logic [31:0] ex_maddr;
   logic [31:0] ex_sdata;
   logic        stall_req;
   logic        mem_we;
   logic [4:0]  mem_waddr;
   logic [31:0] mem_wdata;

   int checks = 0;
   int errors = 0;

   mem_stage_lsu_if #(.XLEN(32)) bus ();

   mem_stage_lsu #(.XLEN(32), .RAW(5)) dut (
      .clk       (clk),
      .rst       (rst),
      .rdy       (rdy),
      .ex_we     (ex_we),
      .ex_waddr  (ex_waddr),
      .ex_wdata  (ex_wdata),
      .ex_memop  (ex_memop),
      .ex_maddr  (ex_maddr),
      .ex_sdata  (ex_sdata),
      .bus       (bus),
      .stall_req (stall_req),
      .mem_we    (mem_we),
      .mem_waddr (mem_waddr),
      .mem_wdata (mem_wdata)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0]  op;
      logic [31:0] addr;
      logic [31:0] sdata;
      logic [4:0]  waddr;
      logic [31:0] rbytes;   // byte k returned for the k-th read
      logic [2:0]  nbytes;
      logic [15:0] gaps;     // idle-ack cycles before byte k, nibble k
      logic [2:0]  hold_at;  // byte index before which rdy drops for 2 cycles, 7 = never
      logic        exp_we;
      logic [31:0] exp_wdata;
   } vec_t;

   vec_t vecs [10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int          stalls;
      int          exp_stalls;
      logic [31:0] addr_k;
      logic        is_st;
      is_st      = (v.op >= 4'd6) && (v.op <= 4'd8);
      stalls     = 0;
      exp_stalls = 1 + int'(v.nbytes) + ((int'(v.hold_at) < int'(v.nbytes)) ? 2 : 0);
      for (int k = 0; k < int'(v.nbytes); k++) exp_stalls += int'(v.gaps[4*k +: 4]);

      ex_memop = v.op;
      ex_maddr = v.addr;
      ex_sdata = v.sdata;
      ex_waddr = v.waddr;
      ex_we    = 1'b1;
      ex_wdata = 32'h0BAD_0BAD;
      #1;
      check($sformatf("v%0d idle mem_we", idx), 32'(mem_we), 32'd0);
      check($sformatf("v%0d idle bus_req", idx), 32'(bus.req), 32'd0);
      stalls += int'(stall_req);
      @(negedge clk);

      for (int k = 0; k < int'(v.nbytes); k++) begin
         addr_k = v.addr + 32'(k);
         if (k == int'(v.hold_at)) begin
            repeat (2) begin
               rdy       = 1'b0;
               bus.ack   = 1'b1;
               bus.rdata = 8'hEE;
               #1;
               check($sformatf("v%0d hold addr b%0d", idx, k), bus.addr, addr_k);
               stalls += int'(stall_req);
               @(negedge clk);
            end
         end
         rdy     = 1'b1;
         bus.ack = 1'b0;
         for (int g = 0; g < int'(v.gaps[4*k +: 4]); g++) begin
            #1;
            check($sformatf("v%0d gap addr b%0d", idx, k), bus.addr, addr_k);
            stalls += int'(stall_req);
            @(negedge clk);
         end
         bus.ack   = 1'b1;
         bus.rdata = v.rbytes[8*k +: 8];
         #1;
         check($sformatf("v%0d bus_req b%0d", idx, k), 32'(bus.req), 32'd1);
         check($sformatf("v%0d bus_addr b%0d", idx, k), bus.addr, addr_k);
         check($sformatf("v%0d bus_we b%0d", idx, k), 32'(bus.we), 32'(is_st));
         if (is_st) check($sformatf("v%0d bus_wdata b%0d", idx, k), 32'(bus.wdata), 32'(v.sdata[8*k +: 8]));
         stalls += int'(stall_req);
         @(negedge clk);
         bus.ack = 1'b0;
      end

      #1;
      check($sformatf("v%0d done stall", idx), 32'(stall_req), 32'd0);
      check($sformatf("v%0d done bus_req", idx), 32'(bus.req), 32'd0);
      check($sformatf("v%0d done mem_we", idx), 32'(mem_we), 32'(v.exp_we));
      check($sformatf("v%0d done mem_wdata", idx), mem_wdata, v.exp_wdata);
      if (v.exp_we) check($sformatf("v%0d done mem_waddr", idx), 32'(mem_waddr), 32'(v.waddr));
      check($sformatf("v%0d stall cycles", idx), 32'(stalls), 32'(exp_stalls));
      $display("vec %0d op=%0d addr=%08h mem_we=%0b mem_wdata=%08h stalls=%0d",
               idx, v.op, v.addr, mem_we, mem_wdata, stalls);

      // Op is still presented after DONE; the block must be idle, not restarted.
      @(negedge clk);
      #1;
      check($sformatf("v%0d no retrigger", idx), 32'(bus.req), 32'd0);
      ex_memop = 4'd0;
   endtask

   task automatic check_pass(input string name, input logic we, input logic [4:0] wa, input logic [31:0] wd);
      #1;
      check({name, " mem_we"}, 32'(mem_we), 32'(we));
      check({name, " mem_waddr"}, 32'(mem_waddr), 32'(wa));
      check({name, " mem_wdata"}, mem_wdata, wd);
      check({name, " stall"}, 32'(stall_req), 32'd0);
      check({name, " bus_req"}, 32'(bus.req), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{op:4'd3, addr:32'h0000_0100, sdata:32'h0, waddr:5'd3, rbytes:32'h1234_5678,
                  nbytes:3'd4, gaps:16'h0000, hold_at:3'd7, exp_we:1'b1, exp_wdata:32'h1234_5678};
      vecs[1] = '{op:4'd1, addr:32'h0000_0203, sdata:32'h0, waddr:5'd4, rbytes:32'h0000_0080,
                  nbytes:3'd1, gaps:16'h0000, hold_at:3'd7, exp_we:1'b1, exp_wdata:32'hFFFF_FF80};
      vecs[2] = '{op:4'd4, addr:32'h0000_0203, sdata:32'h0, waddr:5'd4, rbytes:32'h0000_0080,
                  nbytes:3'd1, gaps:16'h0000, hold_at:3'd7, exp_we:1'b1, exp_wdata:32'h0000_0080};
      vecs[3] = '{op:4'd2, addr:32'h0000_03FF, sdata:32'h0, waddr:5'd6, rbytes:32'h0000_F001,
                  nbytes:3'd2, gaps:16'h0000, hold_at:3'd7, exp_we:1'b1, exp_wdata:32'hFFFF_F001};
      vecs[4] = '{op:4'd5, addr:32'h0000_03FF, sdata:32'h0, waddr:5'd6, rbytes:32'h0000_F001,
                  nbytes:3'd2, gaps:16'h0000, hold_at:3'd7, exp_we:1'b1, exp_wdata:32'h0000_F001};
      vecs[5] = '{op:4'd7, addr:32'hFFFF_FFFF, sdata:32'hAABB_CCDD, waddr:5'd8, rbytes:32'h0,
                  nbytes:3'd2, gaps:16'h0000, hold_at:3'd7, exp_we:1'b0, exp_wdata:32'h0};
      vecs[6] = '{op:4'd6, addr:32'h0000_0010, sdata:32'h1234_565A, waddr:5'd8, rbytes:32'h0,
                  nbytes:3'd1, gaps:16'h0000, hold_at:3'd7, exp_we:1'b0, exp_wdata:32'h0};
      vecs[7] = '{op:4'd8, addr:32'h0000_0020, sdata:32'hDEAD_BEEF, waddr:5'd8, rbytes:32'h0,
                  nbytes:3'd4, gaps:16'h0000, hold_at:3'd7, exp_we:1'b0, exp_wdata:32'h0};
      vecs[8] = '{op:4'd1, addr:32'h0000_0044, sdata:32'h0, waddr:5'd0, rbytes:32'h0000_007F,
                  nbytes:3'd1, gaps:16'h0000, hold_at:3'd7, exp_we:1'b1, exp_wdata:32'h0000_007F};
      vecs[9] = '{op:4'd3, addr:32'h0000_0500, sdata:32'h0, waddr:5'd9, rbytes:32'hDEAD_BEEF,
                  nbytes:3'd4, gaps:16'h2130, hold_at:3'd2, exp_we:1'b1, exp_wdata:32'hDEAD_BEEF};

      rst       = 1'b1;
      rdy       = 1'b1;
      ex_we     = 1'b1;
      ex_waddr  = 5'd5;
      ex_wdata  = 32'h1234_5678;
      ex_memop  = 4'd0;
      ex_maddr  = 32'h0;
      ex_sdata  = 32'h0;
      bus.ack   = 1'b0;
      bus.rdata = 8'h00;
      repeat (2) @(negedge clk);

      // Idle under reset: outputs forced low despite a live pass-through request.
      #1;
      check("reset mem_we", 32'(mem_we), 32'd0);
      check("reset mem_waddr", 32'(mem_waddr), 32'd0);
      check("reset mem_wdata", mem_wdata, 32'd0);
      check("reset stall", 32'(stall_req), 32'd0);
      check("reset bus_req", 32'(bus.req), 32'd0);
      rst = 1'b0;
      check_pass("pass none", 1'b1, 5'd5, 32'h1234_5678);
      @(negedge clk);

      ex_we    = 1'b0;
      ex_waddr = 5'd3;
      ex_wdata = 32'h0000_0000;
      check_pass("pass we0", 1'b0, 5'd3, 32'h0);
      @(negedge clk);

      ex_memop = 4'd12;
      ex_we    = 1'b1;
      ex_waddr = 5'd17;
      ex_wdata = 32'h8000_0001;
      check_pass("pass op12", 1'b1, 5'd17, 32'h8000_0001);
      @(negedge clk);
      #1;
      check("op12 no start", 32'(bus.req), 32'd0);
      ex_memop = 4'd0;
      @(negedge clk);

      for (int i = 0; i < 10; i++) begin
         run_vec(vecs[i], i);
         @(negedge clk);
      end

      // Reset while the second byte of a SW is outstanding.
      ex_memop = 4'd8;
      ex_maddr = 32'h0000_0040;
      ex_sdata = 32'h1122_3344;
      ex_waddr = 5'd9;
      ex_we    = 1'b0;
      #1;
      check("rst idle stall", 32'(stall_req), 32'd1);
      @(negedge clk);
      bus.ack = 1'b1;
      #1;
      check("rst b0 wdata", 32'(bus.wdata), 32'h44);
      @(negedge clk);
      bus.ack = 1'b0;
      rst     = 1'b1;
      #1;
      check("rst b1 bus_req", 32'(bus.req), 32'd1);
      check("rst b1 bus_addr", bus.addr, 32'h0000_0041);
      @(negedge clk);
      #1;
      check("rst after bus_req", 32'(bus.req), 32'd0);
      check("rst after stall", 32'(stall_req), 32'd0);
      check("rst after mem_we", 32'(mem_we), 32'd0);
      check("rst after mem_wdata", mem_wdata, 32'd0);
      check("rst after bus_addr", bus.addr, 32'd0);
      rst      = 1'b0;
      ex_memop = 4'd0;
      ex_we    = 1'b1;
      ex_waddr = 5'd7;
      ex_wdata = 32'hCAFE_F00D;
      check_pass("post rst pass", 1'b1, 5'd7, 32'hCAFE_F00D);
      @(negedge clk);
      check_pass("post rst pass2", 1'b1, 5'd7, 32'hCAFE_F00D);
      $display("reset-abort sequence complete");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
